// File: rtl/gen_debug_pkg.sv
// Shared seven-segment helpers for the on-board debug displays.
// Segment bit order is {dp,g,f,e,d,c,b,a}, with 1 meaning the segment is lit.
package gen_debug_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
        return SEG7_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to seven-segment pattern, without the decimal point.
module seg7_hex_decoder
    import gen_debug_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = hex_to_seg7(nibble);

endmodule

// File: rtl/debug_dpy_pager.sv
// Multi-page hex debug display scanner with frame-coherent capture, paging,
// leading-zero suppression, per-digit blink and anti-ghost blanking.
module debug_dpy_pager
    import gen_debug_pkg::*;
#(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned N_PAGES      = 4,
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_HZ     = 2,
    parameter int unsigned PAGE_HOLD    = 2 * CLK_HZ
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [N_PAGES*32-1:0]                         page_words,
    input  logic [N_PAGES*DIGITS-1:0]                     page_dp,
    input  logic                                          page_next,
    input  logic                                          auto_rotate,
    input  logic                                          zero_suppress,
    input  logic [DIGITS-1:0]                             blink_mask,
    output logic [7:0]                                    seg,
    output logic [DIGITS-1:0]                             scan,
    output logic [((N_PAGES > 1) ? $clog2(N_PAGES) : 1)-1:0] page_o
);

    localparam int unsigned PW        = (N_PAGES > 1) ? $clog2(N_PAGES) : 1;
    localparam int unsigned IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned SW        = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned TW        = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;

    logic [SW-1:0]     scan_cnt;
    logic [IW-1:0]     idx;
    logic [BW-1:0]     blink_cnt;
    logic              blink_on;
    logic [TW-1:0]     page_timer;
    logic              next_q;
    logic              primed;
    logic [31:0]       shadow_word;
    logic [DIGITS-1:0] shadow_dp;

    logic              scan_term;
    logic              frame_wrap;
    logic              advance;
    logic [PW-1:0]     page_inc;
    logic [31:0]       sel_word;
    logic [DIGITS-1:0] sel_dp;
    logic [3:0]        nibble;
    logic              dp_bit;
    logic              blink_bit;
    logic [IW-1:0]     hi_digit;
    logic [6:0]        hex_seg_c;
    logic [7:0]        seg_lit;
    logic              seg_gate;
    logic              in_blank;

    assign scan_term  = (scan_cnt == SW'(SCAN_DIV - 1));
    assign frame_wrap = scan_term && (idx == IW'(DIGITS - 1));
    assign advance    = (page_next && !next_q) ||
                        (auto_rotate && (page_timer == TW'(PAGE_HOLD - 1)));
    assign page_inc   = (page_o == PW'(N_PAGES - 1)) ? '0 : page_o + PW'(1);
    assign in_blank   = (scan_cnt < SW'(BLANK_CYCLES));

    // Source page for the next frame capture
    always_comb begin
        sel_word = page_words[31:0];
        sel_dp   = page_dp[DIGITS-1:0];
        for (int p = 0; p < N_PAGES; p++) begin
            if (page_o == PW'(p)) begin
                sel_word = page_words[32*p +: 32];
                sel_dp   = page_dp[DIGITS*p +: DIGITS];
            end
        end
    end

    // Current-digit mux and highest nonzero nibble for zero suppression
    always_comb begin
        nibble    = shadow_word[3:0];
        dp_bit    = shadow_dp[0];
        blink_bit = blink_mask[0];
        hi_digit  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nibble    = shadow_word[4*i +: 4];
                dp_bit    = shadow_dp[i];
                blink_bit = blink_mask[i];
            end
            if (shadow_word[4*i +: 4] != 4'h0) begin
                hi_digit = IW'(i);
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble (nibble),
        .seg_c  (hex_seg_c)
    );

    always_comb begin
        seg_lit                = '0;
        seg_lit[SEG_DP]        = dp_bit;
        seg_lit[SEG_G:SEG_A]   = hex_seg_c;
        seg_gate               = (zero_suppress && (idx > hi_digit)) ||
                                 (!blink_on && blink_bit);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt    <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            page_timer  <= '0;
            page_o      <= '0;
            next_q      <= 1'b0;
            primed      <= 1'b0;
            shadow_word <= '0;
            shadow_dp   <= '0;
            seg         <= '0;
            scan        <= '0;
        end else begin
            scan_cnt <= scan_term ? '0 : scan_cnt + SW'(1);
            if (scan_term) begin
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end

            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            // A button edge and a timeout in the same cycle collapse into one advance
            next_q <= page_next;
            if (advance) begin
                page_o     <= page_inc;
                page_timer <= '0;
            end else if (auto_rotate) begin
                page_timer <= page_timer + TW'(1);
            end else begin
                page_timer <= '0;
            end

            primed <= 1'b1;
            if (frame_wrap || !primed) begin
                shadow_word <= sel_word;
                shadow_dp   <= sel_dp;
            end

            if (in_blank) begin
                seg  <= '0;
                scan <= '0;
            end else begin
                scan <= DIGITS'(1) << idx;
                seg  <= seg_gate ? 8'h00 : seg_lit;
            end
        end
    end

endmodule

// File: tb/tb_debug_dpy_pager.sv
// Self-checking bench for debug_dpy_pager: stimulus table, corner-case sequences
// and a randomized run against a frame-level reference model.
module tb_debug_dpy_pager;

    localparam int NP = 4;
    localparam int ND = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [127:0]  page_words = '0;
    logic [31:0]   page_dp = '0;
    logic          page_next = 1'b0;
    logic          auto_rotate = 1'b0;
    logic          zero_suppress = 1'b0;
    logic [7:0]    blink_mask = '0;
    logic [7:0]    seg;
    logic [7:0]    scan;
    logic [1:0]    page_o;

    debug_dpy_pager #(
        .DIGITS       (ND),
        .N_PAGES      (NP),
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2),
        .BLINK_HZ     (25),
        .PAGE_HOLD    (200)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .page_words    (page_words),
        .page_dp       (page_dp),
        .page_next     (page_next),
        .auto_rotate   (auto_rotate),
        .zero_suppress (zero_suppress),
        .blink_mask    (blink_mask),
        .seg           (seg),
        .scan          (scan),
        .page_o        (page_o)
    );

    always #5 clock = ~clock;

    logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: edges since reset, displayed frame snapshot, paging
    int          k;
    logic [31:0] m_shadow;
    logic [7:0]  m_sdp;
    int          m_page;
    int          m_timer;
    logic        m_prev;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  dp;
        logic        zs;
        int          digit;
        logic [7:0]  exp_seg;
        logic [7:0]  exp_scan;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0h, expected %0h", name, k, act, exp);
    endtask

    // One clock edge: predict outputs from pre-edge state, then advance the model
    task automatic tick();
        int          cnt, d, hi;
        logic        ph_on;
        logic [3:0]  nib;
        logic [7:0]  es, ec;
        logic        rise;
        @(posedge clock);
        cnt   = k % 10;
        d     = (k / 10) % 8;
        ph_on = ((k / 20) % 2) == 0;
        es = 8'h00;
        ec = 8'h00;
        if (cnt >= 2) begin
            ec  = 8'(1) << d;
            nib = 4'((m_shadow >> (4 * d)) & 32'hF);
            hi  = 0;
            for (int i = 0; i < 8; i++)
                if (((m_shadow >> (4 * i)) & 32'hF) != 0) hi = i;
            if (!((zero_suppress && d > hi) || (!ph_on && blink_mask[d])))
                es = {m_sdp[d], hex_tab[nib]};
        end
        if (k + 1 == 1 || (k + 1) % 80 == 0) begin
            m_shadow = page_words[32*m_page +: 32];
            m_sdp    = page_dp[8*m_page +: 8];
        end
        rise = page_next && !m_prev;
        m_prev = page_next;
        if (rise || (auto_rotate && m_timer == 199)) begin
            m_page  = (m_page + 1) % NP;
            m_timer = 0;
        end else begin
            m_timer = auto_rotate ? m_timer + 1 : 0;
        end
        k++;
        #1;
        check("seg", 32'(seg), 32'(es));
        check("scan", 32'(scan), 32'(ec));
        check("page_o", 32'(page_o), 32'(m_page));
    endtask

    task automatic run_to(input int n);
        while (k < n) tick();
    endtask

    // Asserts reset immediately, checks the async clear, releases on a falling edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_scan", 32'(scan), 32'h0);
        check("rst_page", 32'(page_o), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset    = 1'b0;
        k        = 0;
        m_shadow = '0;
        m_sdp    = '0;
        m_page   = 0;
        m_timer  = 0;
        m_prev   = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h1234_ABCD, 8'h00, 1'b0, 0, 8'h5E, 8'h01};
        vecs[1]  = '{32'h1234_ABCD, 8'h00, 1'b0, 7, 8'h06, 8'h80};
        vecs[2]  = '{32'h1234_ABCD, 8'h00, 1'b0, 4, 8'h66, 8'h10};
        vecs[3]  = '{32'h1234_ABCD, 8'h00, 1'b0, 1, 8'h39, 8'h02};
        vecs[4]  = '{32'h1234_ABCD, 8'h00, 1'b0, 2, 8'h7C, 8'h04};
        vecs[5]  = '{32'h1234_ABCD, 8'h00, 1'b0, 3, 8'h77, 8'h08};
        vecs[6]  = '{32'h1234_ABCD, 8'h00, 1'b0, 5, 8'h4F, 8'h20};
        vecs[7]  = '{32'h1234_ABCD, 8'h00, 1'b0, 6, 8'h5B, 8'h40};
        vecs[8]  = '{32'h0000_0000, 8'h00, 1'b1, 0, 8'h3F, 8'h01};
        vecs[9]  = '{32'h0000_0000, 8'h00, 1'b1, 3, 8'h00, 8'h08};
        vecs[10] = '{32'h0000_0000, 8'h00, 1'b0, 3, 8'h3F, 8'h08};
        vecs[11] = '{32'h0000_0008, 8'h01, 1'b1, 0, 8'hFF, 8'h01};
        vecs[12] = '{32'h00F0_0000, 8'h80, 1'b1, 7, 8'h00, 8'h80};
        vecs[13] = '{32'h00F0_0000, 8'h00, 1'b1, 5, 8'h71, 8'h20};
        vecs[14] = '{32'h00F0_0000, 8'h10, 1'b1, 4, 8'hBF, 8'h10};
        vecs[15] = '{32'hE900_0000, 8'h00, 1'b1, 6, 8'h6F, 8'h40};
        vecs[16] = '{32'hE900_0000, 8'h00, 1'b1, 7, 8'h79, 8'h80};
        vecs[17] = '{32'h5670_0000, 8'h00, 1'b1, 5, 8'h07, 8'h20};
        vecs[18] = '{32'h5670_0000, 8'h00, 1'b1, 6, 8'h7D, 8'h40};
        vecs[19] = '{32'h5670_0000, 8'h00, 1'b1, 7, 8'h6D, 8'h80};

        k = 0;
        #2;
        do_reset();

        // Table: one digit of one captured word per entry
        foreach (vecs[v]) begin
            @(negedge clock);
            do_reset();
            page_words         = {$urandom, $urandom, $urandom, vecs[v].word};
            page_dp            = {24'h0, vecs[v].dp};
            zero_suppress      = vecs[v].zs;
            blink_mask         = 8'h00;
            run_to(10 * vecs[v].digit + 6);
            check($sformatf("tab%0d_seg", v), 32'(seg), 32'(vecs[v].exp_seg));
            check($sformatf("tab%0d_scan", v), 32'(scan), 32'(vecs[v].exp_scan));
        end

        // Scan walk, blanking and reset in the middle of digit 3
        @(negedge clock);
        zero_suppress = 1'b0;
        page_dp       = '0;
        page_words    = {96'h0, 32'h1234_ABCD};
        do_reset();
        run_to(1);
        check("walk_blank0", 32'(scan), 32'h0);
        run_to(3);
        check("walk_dig0", 32'(scan), 32'h01);
        run_to(36);
        check("pre_rst_scan", 32'(scan), 32'h08);
        #2;
        do_reset();

        // Page data changes mid-frame must not tear
        run_to(46);
        page_words[31:0] = 32'h0;
        zero_suppress    = 1'b1;
        run_to(76);
        check("tear_d7_seg", 32'(seg), 32'h06);
        run_to(86);
        check("frame1_d0_seg", 32'(seg), 32'h3F);
        run_to(136);
        check("frame1_d5_seg", 32'(seg), 32'h00);
        check("frame1_d5_scan", 32'(scan), 32'h20);

        // Held button gives one advance; four edges wrap
        @(negedge clock);
        page_words = {$urandom, $urandom, $urandom, $urandom};
        page_next  = 1'b1;
        do_reset();
        run_to(500);
        check("held_once", 32'(page_o), 32'h1);
        for (int e = 0; e < 3; e++) begin
            page_next = 1'b0;
            run_to(k + 3);
            page_next = 1'b1;
            run_to(k + 3);
        end
        check("wrap", 32'(page_o), 32'h0);
        page_next = 1'b0;

        // Auto rotation and a coincident button edge
        @(negedge clock);
        auto_rotate = 1'b1;
        do_reset();
        run_to(199);
        check("auto_199", 32'(page_o), 32'h0);
        run_to(200);
        check("auto_200", 32'(page_o), 32'h1);
        run_to(399);
        page_next = 1'b1;
        run_to(400);
        check("coincide", 32'(page_o), 32'h2);
        page_next = 1'b0;
        run_to(599);
        check("auto_599", 32'(page_o), 32'h2);
        run_to(600);
        check("auto_600", 32'(page_o), 32'h3);
        auto_rotate = 1'b0;

        // Blink phases and decimal point
        @(negedge clock);
        zero_suppress = 1'b0;
        page_words    = {96'h0, 32'h8888_8888};
        page_dp       = '0;
        blink_mask    = 8'hFF;
        do_reset();
        run_to(6);
        check("blink_on_d0", 32'(seg), 32'h7F);
        run_to(26);
        check("blink_off_d2", 32'(seg), 32'h00);
        check("blink_off_scan", 32'(scan), 32'h04);
        run_to(46);
        check("blink_on_d4", 32'(seg), 32'h7F);
        page_dp = 32'h1;
        run_to(66);
        check("blink_off_d6", 32'(seg), 32'h00);
        run_to(86);
        check("blink_dp_d0", 32'(seg), 32'hFF);

        // Randomized traffic against the model
        @(negedge clock);
        blink_mask = 8'($urandom);
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 49) == 0)
                page_words[32*$urandom_range(0, 3) +: 32] = $urandom >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 49) == 0) page_dp = $urandom;
            if ($urandom_range(0, 99) == 0) zero_suppress = ~zero_suppress;
            if ($urandom_range(0, 59) == 0) blink_mask = 8'($urandom);
            if ($urandom_range(0, 299) == 0) auto_rotate = ~auto_rotate;
            if ($urandom_range(0, 39) == 0) page_next = ~page_next;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
